// File: rtl/i2c_config_sequencer.sv
// Walks a table of register writes to one I2C device through the write transmitter,
// with per-attempt timeout and bounded retry via a transmitter reset pulse.
module i2c_config_sequencer #(
  parameter int         NUM_REGS       = 11,
  parameter int         IDX_W          = 4,
  parameter logic [6:0] DEV_ADDR       = 7'h1A,
  parameter int         GAP_CYCLES     = 4,
  parameter int         TIMEOUT_CYCLES = 255,
  parameter int         MAX_RETRY      = 2
) (
  input  logic             CLK_200KHZ,
  input  logic             RESET,
  input  logic             GO,
  output logic [IDX_W-1:0] TBL_INDEX,
  input  logic [7:0]       TBL_REG_ADDR,
  input  logic [7:0]       TBL_DATA,
  input  logic             TX_READY,
  input  logic             TX_END,
  input  logic             TX_ERROR,
  output logic             TX_START,
  output logic             TX_STOP,
  output logic             TX_RESET,
  output logic [6:0]       TX_DEV_ADDR,
  output logic [7:0]       TX_REG_ADDR,
  output logic [7:0]       TX_DATA,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + GAP_CYCLES + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 2);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_READY, S_ISSUE, S_WAIT_END, S_RELEASE,
    S_GAP, S_RECOVER, S_DONE, S_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rec_ph_q, rec_ph_d;
  logic             latch_en;
  logic             tx_rst_int_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    retry_d  = retry_q;
    cnt_d    = cnt_q;
    rec_ph_d = 1'b0;
    latch_en = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_FAULT: begin
        if (GO) begin
          idx_d   = '0;
          retry_d = '0;
          state_d = S_WAIT_READY;
        end
      end
      S_WAIT_READY: begin
        if (TX_READY) begin
          latch_en = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(TIMEOUT_CYCLES - 1);
        state_d = S_WAIT_END;
      end
      S_WAIT_END: begin
        // error has priority over a coincident END
        if (TX_ERROR)                 state_d = S_RECOVER;
        else if (TX_END)              state_d = S_RELEASE;
        else if (cnt_q <= CNT_W'(1))  state_d = S_RECOVER;
        else                          cnt_d   = cnt_q - CNT_W'(1);
      end
      S_RELEASE: begin
        cnt_d   = CNT_W'(GAP_CYCLES - 1);
        state_d = S_GAP;
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          if (idx_q == IDX_W'(NUM_REGS - 1)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            retry_d = '0;
            state_d = S_WAIT_READY;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RECOVER: begin
        if (!rec_ph_q) begin
          rec_ph_d = 1'b1;
        end else begin
          retry_d = retry_q + RTY_W'(1);
          state_d = (retry_q >= RTY_W'(MAX_RETRY)) ? S_FAULT : S_WAIT_READY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_200KHZ or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      retry_q      <= '0;
      cnt_q        <= '0;
      rec_ph_q     <= 1'b0;
      TX_REG_ADDR  <= '0;
      TX_DATA      <= '0;
      TX_START     <= 1'b0;
      TX_STOP      <= 1'b0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      ERR          <= 1'b0;
      tx_rst_int_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      retry_q  <= retry_d;
      cnt_q    <= cnt_d;
      rec_ph_q <= rec_ph_d;
      if (latch_en) begin
        TX_REG_ADDR <= TBL_REG_ADDR;
        TX_DATA     <= TBL_DATA;
      end
      // outputs decoded from the next state so they line up with the state register
      TX_START     <= (state_d == S_ISSUE);
      TX_STOP      <= (state_d == S_RELEASE);
      BUSY         <= !(state_d inside {S_IDLE, S_DONE, S_FAULT});
      DONE         <= (state_d == S_DONE);
      ERR          <= (state_d == S_FAULT);
      tx_rst_int_q <= (state_d == S_RECOVER);
    end
  end

  assign TBL_INDEX   = idx_q;
  assign TX_RESET    = RESET | tx_rst_int_q;
  assign TX_DEV_ADDR = DEV_ADDR;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Randomised bench: behavioural transmitter plus a table-level model of the expected
// START sequence, cycle positions and final DONE/ERR outcome.
`timescale 1ns/1ps
module tb_i2c_config_sequencer;
  localparam int NR = 3, GAP = 4, TMO = 10, MR = 2;

  logic       CLK_200KHZ = 1'b0;
  logic       RESET;
  always #5 CLK_200KHZ = ~CLK_200KHZ;

  logic       go, tx_ready, tx_end, tx_error;
  logic [3:0] tbl_index;
  logic [7:0] tbl_reg_addr, tbl_data, tx_reg_addr, tx_data;
  logic       tx_start, tx_stop, tx_reset, busy, done, err;
  logic [6:0] tx_dev_addr;
  logic [7:0] tbl_a [16];
  logic [7:0] tbl_d [16];

  assign tbl_reg_addr = tbl_a[tbl_index];
  assign tbl_data     = tbl_d[tbl_index];

  i2c_config_sequencer #(.NUM_REGS(NR), .IDX_W(4), .DEV_ADDR(7'h1A), .GAP_CYCLES(GAP),
                         .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MR)) u_dut (
    .CLK_200KHZ(CLK_200KHZ), .RESET(RESET), .GO(go), .TBL_INDEX(tbl_index),
    .TBL_REG_ADDR(tbl_reg_addr), .TBL_DATA(tbl_data), .TX_READY(tx_ready),
    .TX_END(tx_end), .TX_ERROR(tx_error), .TX_START(tx_start), .TX_STOP(tx_stop),
    .TX_RESET(tx_reset), .TX_DEV_ADDR(tx_dev_addr), .TX_REG_ADDR(tx_reg_addr),
    .TX_DATA(tx_data), .BUSY(busy), .DONE(done), .ERR(err));

  // single-entry instance with a one-clock gap
  logic       o_go, o_ready, o_end, o_start, o_stop, o_reset, o_busy, o_done, o_err;
  logic [3:0] o_index;
  logic [6:0] o_dev_addr;
  logic [7:0] o_reg_addr, o_data;

  i2c_config_sequencer #(.NUM_REGS(1), .IDX_W(4), .DEV_ADDR(7'h1A), .GAP_CYCLES(1),
                         .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MR)) u_one (
    .CLK_200KHZ(CLK_200KHZ), .RESET(RESET), .GO(o_go), .TBL_INDEX(o_index),
    .TBL_REG_ADDR(8'h3C), .TBL_DATA(8'hA5), .TX_READY(o_ready),
    .TX_END(o_end), .TX_ERROR(1'b0), .TX_START(o_start), .TX_STOP(o_stop),
    .TX_RESET(o_reset), .TX_DEV_ADDR(o_dev_addr), .TX_REG_ADDR(o_reg_addr),
    .TX_DATA(o_data), .BUSY(o_busy), .DONE(o_done), .ERR(o_err));

  typedef struct { logic [7:0] a; logic [7:0] d; int idx; } exp_t;
  exp_t exp_q [$];
  int   fail_att  [16];   // failing attempts per entry
  int   fail_kind [16];   // 1 = ERROR, 2 = no END (timeout), 3 = END and ERROR together
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_values(input string tag);
    check_eq({tag, "_start"}, tx_start, 0);
    check_eq({tag, "_stop"},  tx_stop, 0);
    check_eq({tag, "_busy"},  busy, 0);
    check_eq({tag, "_done"},  done, 0);
    check_eq({tag, "_err"},   err, 0);
    check_eq({tag, "_index"}, tbl_index, 0);
    check_eq({tag, "_regad"}, tx_reg_addr, 0);
    check_eq({tag, "_data"},  tx_data, 0);
    check_eq({tag, "_txrst"}, tx_reset, 1);
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 16; i++) begin
      fail_att[i]  = 0;
      fail_kind[i] = 1;
    end
  endtask

  task automatic rand_table();
    for (int i = 0; i < 16; i++) begin
      tbl_a[i] = 8'($urandom);
      tbl_d[i] = 8'($urandom);
    end
  endtask

  task automatic run_seq(input bit abort1);
    int cyc, exp_start, exp_fin, rst_first, rst_len, end_cyc, start_cyc;
    int n_stop, n_ok, exp_idx, attempt, last_idx, cnt, kind, abort_cnt;
    bit fault, busy_m, finished, aborted;
    exp_t e;
    exp_q.delete();
    fault = 0; n_ok = 0; exp_idx = NR - 1;
    for (int i = 0; i < NR; i++) begin
      int reps;
      reps = (fail_att[i] > MR) ? MR + 1 : fail_att[i] + 1;
      for (int r = 0; r < reps; r++) exp_q.push_back('{tbl_a[i], tbl_d[i], i});
      if (fail_att[i] > MR) begin
        fault = 1; exp_idx = i;
        break;
      end
      n_ok++;
    end
    cyc = 0; exp_start = 2; exp_fin = -1; rst_len = 0; rst_first = 0; end_cyc = -100;
    start_cyc = 0; n_stop = 0; last_idx = -1; attempt = 0; cnt = 0; kind = 0;
    abort_cnt = 0; busy_m = 0; finished = 0; aborted = 0;
    tx_ready = 1; tx_end = 0; tx_error = 0;
    @(negedge CLK_200KHZ);
    go = 1;
    for (int k = 0; k < 3000 && !finished; k++) begin
      @(negedge CLK_200KHZ);
      cyc++;
      tx_end = 0; tx_error = 0;
      if (cyc == 1) begin
        check_eq("go_busy", busy, 1);
        check_eq("go_done", done, 0);
        check_eq("go_err",  err, 0);
      end
      if (tx_reset) begin
        if (rst_len == 0) begin
          rst_first = cyc;
          if (kind == 2) check_eq("timeout_lat", cyc - start_cyc, TMO);
        end
        rst_len++; busy_m = 0; tx_ready = 0;
      end else if (rst_len > 0) begin
        check_eq("rst_len", rst_len, 2);
        rst_len = 0; tx_ready = 1;
        exp_start = rst_first + 3; exp_fin = rst_first + 2;
      end
      if (tx_stop) begin
        check_eq("stop_lat", cyc - end_cyc, 1);
        n_stop++;
      end
      if (tx_start) begin
        check_eq("start_cyc", cyc, exp_start);
        check_eq("dev_addr", tx_dev_addr, 7'h1A);
        check_eq("q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("reg_addr", tx_reg_addr, e.a);
          check_eq("data", tx_data, e.d);
          check_eq("start_idx", tbl_index, e.idx);
        end
        if (int'(tbl_index) == last_idx) attempt++;
        else begin attempt = 0; last_idx = int'(tbl_index); end
        kind = (attempt < fail_att[tbl_index]) ? fail_kind[tbl_index] : 0;
        cnt = $urandom_range(2, 7);
        start_cyc = cyc; busy_m = 1; tx_ready = 0;
        if (abort1 && tbl_index == 4'd1) abort_cnt = 2;
      end else if (busy_m) begin
        cnt--;
        if (cnt == 0) begin
          busy_m = 0;
          case (kind)
            0: begin
              tx_end = 1; tx_ready = 1; end_cyc = cyc;
              exp_start = cyc + 3 + GAP; exp_fin = cyc + 2 + GAP;
            end
            1: tx_error = 1;
            3: begin tx_end = 1; tx_error = 1; end
            default: ;
          endcase
        end
      end
      if (abort_cnt > 0) begin
        abort_cnt--;
        if (abort_cnt == 0) begin
          #2 RESET = 1;
          #1 reset_values("abort");
          aborted = 1; finished = 1;
        end
      end
      if (!aborted && (done || err)) begin
        finished = 1;
        check_eq("fin_cyc", cyc, exp_fin);
      end
      go = !finished && ($urandom_range(0, 7) == 0);
    end
    go = 0;
    check_eq("seq_finished", finished, 1);
    if (!aborted) begin
      check_eq("end_done",  done, !fault);
      check_eq("end_err",   err, fault);
      check_eq("end_index", tbl_index, exp_idx);
      check_eq("end_busy",  busy, 0);
      check_eq("q_left",    exp_q.size(), 0);
      check_eq("stops",     n_stop, n_ok);
    end else begin
      repeat (2) @(negedge CLK_200KHZ);
      RESET = 0; tx_end = 0; tx_error = 0; tx_ready = 1;
      @(negedge CLK_200KHZ);
    end
  endtask

  task automatic run_one();
    int cyc, start_c, stop_c, end_c, n_s, n_p;
    bit fin;
    cyc = 0; start_c = -100; stop_c = -100; end_c = -100; n_s = 0; n_p = 0; fin = 0;
    o_ready = 1;
    @(negedge CLK_200KHZ);
    o_go = 1;
    for (int k = 0; k < 200 && !fin; k++) begin
      @(negedge CLK_200KHZ);
      cyc++;
      o_go = 0; o_end = 0;
      if (o_start) begin
        n_s++; start_c = cyc;
        check_eq("one_regad", o_reg_addr, 8'h3C);
        check_eq("one_data",  o_data, 8'hA5);
        check_eq("one_dev",   o_dev_addr, 7'h1A);
      end
      check_eq("one_index", o_index, 0);
      if (o_stop) begin
        n_p++; stop_c = cyc;
        check_eq("one_stop_lat", cyc - end_c, 1);
      end
      if (cyc == start_c + 3) begin o_end = 1; end_c = cyc; end
      if (o_done) begin
        fin = 1;
        check_eq("one_done_lat", cyc - stop_c, 2);
      end
    end
    check_eq("one_finished", fin, 1);
    check_eq("one_starts", n_s, 1);
    check_eq("one_stops", n_p, 1);
    check_eq("one_busy", o_busy, 0);
    check_eq("one_err", o_err, 0);
    check_eq("one_txrst", o_reset, 0);
  endtask

  initial begin
    RESET = 1; go = 0; tx_ready = 1; tx_end = 0; tx_error = 0;
    o_go = 0; o_ready = 0; o_end = 0;
    for (int i = 0; i < 16; i++) begin tbl_a[i] = 8'h00; tbl_d[i] = 8'h00; end
    tbl_a[0] = 8'h1E; tbl_d[0] = 8'h00;
    tbl_a[1] = 8'h06; tbl_d[1] = 8'h10;
    tbl_a[2] = 8'h09; tbl_d[2] = 8'h01;
    clear_plan();
    repeat (3) @(negedge CLK_200KHZ);
    reset_values("rst");
    RESET = 0;
    @(negedge CLK_200KHZ);
    check_eq("rst_release_txrst", tx_reset, 0);

    run_seq(0);                                   // clean pass over the codec table
    fail_att[1] = 1; fail_kind[1] = 1;
    run_seq(0);                                   // single error, retried
    clear_plan(); fail_att[2] = 9; fail_kind[2] = 1;
    run_seq(0);                                   // persistent error -> FAULT at 2
    clear_plan();
    run_seq(0);                                   // GO out of FAULT
    fail_att[0] = 9; fail_kind[0] = 2;
    run_seq(0);                                   // timeouts -> FAULT at 0
    clear_plan(); fail_att[0] = 1; fail_kind[0] = 3; fail_att[2] = 2; fail_kind[2] = 2;
    run_seq(0);                                   // END+ERROR together, then two timeouts
    for (int s = 0; s < 6; s++) begin
      rand_table();
      for (int i = 0; i < NR; i++) begin
        fail_att[i]  = $urandom_range(0, 3);
        fail_kind[i] = $urandom_range(1, 3);
      end
      run_seq(0);
    end
    clear_plan(); rand_table();
    run_seq(1);                                   // async reset during entry 1
    run_seq(0);
    run_one();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/i2c_config_sequencer.md
Name: i2c_config_sequencer

Overview:
- Sequences the I2C write transmitter through a table of NUM_REGS register writes to one device, e.g. codec power-up configuration.
- Fetches each entry from an external table and drives the transmitter's START/STOP handshake.
- Recovers from transmitter error or timeout by resetting the transmitter, with bounded retries.
- Sits between top-level control (GO/DONE/ERR) and the transmitter, in the 200 kHz domain.

Parameters:
NUM_REGS, 11, number of table entries written per sequence (>=1)
IDX_W, 4, width of TBL_INDEX; 2^IDX_W >= NUM_REGS
DEV_ADDR, 7'h1A, 7-bit slave address driven on TX_DEV_ADDR
GAP_CYCLES, 4, idle clocks between STOP and next START (>=1)
TIMEOUT_CYCLES, 255, max clocks waiting for TX_END per attempt
MAX_RETRY, 2, retries per entry before FAULT

Ports:
CLK_200KHZ  in  1  system clock; all logic on posedge
RESET  in  1  asynchronous, active-high reset
GO  in  1  start sequence; sampled in IDLE, DONE, FAULT; ignored otherwise
TBL_INDEX  out  IDX_W  current table entry index
TBL_REG_ADDR  in  8  register address of entry TBL_INDEX (combinational table)
TBL_DATA  in  8  data byte of entry TBL_INDEX
TX_READY  in  1  transmitter READY
TX_END  in  1  transmitter END
TX_ERROR  in  1  transmitter ERROR_LED
TX_START  out  1  transmitter START
TX_STOP  out  1  transmitter STOP
TX_RESET  out  1  transmitter reset = RESET OR internal recover pulse
TX_DEV_ADDR  out  7  constant DEV_ADDR
TX_REG_ADDR  out  8  latched register address
TX_DATA  out  8  latched data
BUSY  out  1  high in every state except IDLE, DONE, FAULT
DONE  out  1  high in DONE
ERR  out  1  high in FAULT

Behaviour:
- Reset (async):
  - state=IDLE; TBL_INDEX=0; TX_REG_ADDR=TX_DATA=0; retry=0; counters=0.
  - TX_START=TX_STOP=BUSY=DONE=ERR=0; TX_RESET=1 while RESET high.
- All outputs except TX_RESET and TX_DEV_ADDR are registered.
- States and transitions:
  - IDLE: GO=1 -> TBL_INDEX=0, retry=0, go WAIT_READY.
  - WAIT_READY: when TX_READY=1, latch TBL_REG_ADDR/TBL_DATA into TX_REG_ADDR/TX_DATA -> ISSUE.
  - ISSUE: TX_START=1 for exactly this one cycle; load timeout counter -> WAIT_END. TX_REG_ADDR/TX_DATA stay stable until the next entry is latched.
  - WAIT_END (TX_START=0):
    - TX_ERROR=1 -> RECOVER.
    - else TX_END=1 -> RELEASE.
    - else counter reaches TIMEOUT_CYCLES -> RECOVER.
    - TX_ERROR and TX_END both 1 in the same cycle: error wins.
  - RELEASE: TX_STOP=1 for exactly one cycle; load gap counter -> GAP.
  - GAP: count GAP_CYCLES clocks, then:
    - if TBL_INDEX==NUM_REGS-1 -> DONE;
    - else TBL_INDEX+1, retry=0 -> WAIT_READY.
  - RECOVER: internal TX_RESET pulse for 2 cycles; retry+1; then:
    - if new retry > MAX_RETRY -> FAULT;
    - else -> WAIT_READY with TBL_INDEX unchanged.
  - DONE: DONE=1. GO=1 -> same action as IDLE (restart at entry 0, DONE drops next cycle).
  - FAULT: ERR=1, TBL_INDEX frozen at the failing entry. GO=1 -> restart as IDLE (ERR drops).
- TBL_INDEX never exceeds NUM_REGS-1 and never wraps.
- Attempts per entry = MAX_RETRY+1.
- TX_READY is not checked outside WAIT_READY.
- GO held high continuously restarts the sequence immediately on entering DONE.
- Mid-operation RESET aborts the sequence with no STOP issued; the transmitter is reset concurrently through TX_RESET.
- Start-to-start period per entry (no errors) = transmitter frame time + 3 + GAP_CYCLES clocks.

Test Plan:
- NUM_REGS=3, table {(0x1E,0x00),(0x06,0x10),(0x09,0x01)}, behavioural transmitter, GO pulse -> 3 TX_START pulses with matching TX_REG_ADDR/TX_DATA; TX_DEV_ADDR=0x1A; TX_STOP one cycle after each TX_END; DONE=1 after third GAP; BUSY=0 in DONE.
- NUM_REGS=1, GAP_CYCLES=1 -> exactly one START/STOP; DONE asserted 2 clocks after TX_STOP; TBL_INDEX stays 0.
- TX_ERROR forced on the first attempt of entry 1 only -> TX_RESET high exactly 2 cycles, entry 1 reissued with identical bytes, sequence completes with DONE=1, ERR never set.
- TX_ERROR forced on every attempt of entry 2, MAX_RETRY=2 -> 3 START pulses for entry 2, then ERR=1, TBL_INDEX=2, BUSY=0; a subsequent GO restarts at index 0 and ERR drops.
- TX_END never asserted, TIMEOUT_CYCLES=10 -> RECOVER entered 10 clocks after ISSUE, each attempt times out, FAULT after 3 attempts.
- RESET asserted mid-frame during entry 1 -> all outputs return to reset values immediately (asynchronously), TX_RESET=1; after release, GO restarts cleanly at entry 0.
